// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared constants and types for the pong ball stage.
//                Holds the visible-screen dimensions, the raster line that
//                carries the per-frame tick, the ball centre used for serves,
//                and the ball FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package pong_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int TICK_LINE = 480;

    // Top-left corner of an 8x8 ball centred on a 640x480 screen
    localparam int CENTRE_X  = 316;
    localparam int CENTRE_Y  = 236;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2
    } state_t;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/pong_ball_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : pong_ball_engine_if
//  Description : Raster and paddle inputs plus ball outputs of the pong ball
//                stage, bundled as one interface.
//  Ports (signals):
//    CounterX[9:0], CounterY[8:0], inDisplayArea : raster position from sync
//    paddle_l_y[8:0], paddle_r_y[8:0]            : paddle top edges
//    ball_pixel, ball_x[9:0], ball_y[8:0]        : ball drawing / position
//    score_l[3:0], score_r[3:0], point_pulse     : scoring
//  Modports   : master = raster/paddle source, slave = ball engine
//  Revision    : 1.0  initial release
// ============================================================================
interface pong_ball_engine_if;

    logic [9:0] CounterX;
    logic [8:0] CounterY;
    logic       inDisplayArea;
    logic [8:0] paddle_l_y;
    logic [8:0] paddle_r_y;

    logic       ball_pixel;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       point_pulse;

    modport master (
        output CounterX, CounterY, inDisplayArea, paddle_l_y, paddle_r_y,
        input  ball_pixel, ball_x, ball_y, score_l, score_r, point_pulse
    );

    modport slave (
        input  CounterX, CounterY, inDisplayArea, paddle_l_y, paddle_r_y,
        output ball_pixel, ball_x, ball_y, score_l, score_r, point_pulse
    );

endinterface : pong_ball_engine_if
`default_nettype wire

// File: rtl/pong_frame_tick.sv
`default_nettype none
// ============================================================================
//  Module      : pong_frame_tick
//  Description : Decodes the raster counters and emits a registered one-cycle
//                pulse once per frame, at the first pixel of TICK_LINE (inside
//                vertical blanking). Shared by the ball and paddle stages.
//  Ports:
//    clk          in  pixel clock
//    rst_n        in  asynchronous active-low reset
//    counter_x_i  in  horizontal pixel counter
//    counter_y_i  in  vertical line counter
//    frame_tick_o out one-cycle pulse per frame
//  Revision    : 1.0  initial release
// ============================================================================
module pong_frame_tick
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] counter_x_i,
    input  logic [8:0] counter_y_i,
    output logic       frame_tick_o
);

    logic frame_tick_q;
    logic frame_tick_d;

    assign frame_tick_d = (counter_y_i == 9'(TICK_LINE)) && (counter_x_i == 10'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick_o = frame_tick_q;

endmodule : pong_frame_tick
`default_nettype wire

// File: rtl/pong_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pong_ball_engine
//  Description : Ball motion and ball pixel stage fed by the VGA sync counters.
//                Moves the ball once per frame, reflects it off the top/bottom
//                walls and the paddles, detects misses, keeps both scores and
//                produces a registered ball_pixel for the colour mux.
//  Ports:
//    clk    in   pixel clock
//    rst_n  in   asynchronous active-low reset
//    bus    slave modport of pong_ball_engine_if (counters, paddles, ball
//           position, ball_pixel, scores, point_pulse)
//  Build option:
//    PONG_BALL_SPEEDUP_EN  when defined, each paddle hit raises the speed by
//                          one up to MAX_SPEED; a point restores SPEED.
//  Revision    : 1.0  initial release
// ============================================================================
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int BALL_SIZE    = 8,
    parameter int SPEED        = 2,
    parameter int MAX_SPEED    = 6,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int LEFT_PAD_X   = 16,
    parameter int RIGHT_PAD_X  = 616,
    parameter int SERVE_FRAMES = 60
)(
    input  logic                clk,
    input  logic                rst_n,
    pong_ball_engine_if.slave   bus
);

    // Speed register sized for the larger of the base speed and the ceiling
    localparam int SPD_W = $clog2(((MAX_SPEED > SPEED) ? MAX_SPEED : SPEED) + 1);
    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [SPD_W-1:0] SPEED_INIT = SPD_W'(SPEED);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SERVE_FRAMES - 1);

    localparam logic signed [10:0] X_MAX     = 11'(H_VISIBLE - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX     = 11'(V_VISIBLE - BALL_SIZE);
    localparam logic signed [10:0] BALL_S    = 11'(BALL_SIZE);
    localparam logic signed [10:0] PAD_H     = 11'(PADDLE_H);
    localparam logic signed [10:0] L_PAD_X   = 11'(LEFT_PAD_X);
    localparam logic signed [10:0] L_PAD_END = 11'(LEFT_PAD_X + PADDLE_W);
    localparam logic signed [10:0] R_PAD_X   = 11'(RIGHT_PAD_X);
    localparam logic signed [10:0] R_PAD_END = 11'(RIGHT_PAD_X + PADDLE_W);

    localparam logic [9:0] L_BOUNCE_X = 10'(LEFT_PAD_X + PADDLE_W);
    localparam logic [9:0] R_BOUNCE_X = 10'(RIGHT_PAD_X - BALL_SIZE);
    localparam logic [9:0] CX         = 10'(CENTRE_X);
    localparam logic [8:0] CY         = 9'(CENTRE_Y);
    localparam logic [8:0] Y_TOP_LIM  = 9'(V_VISIBLE - BALL_SIZE);

    state_t             state_q,       state_d;
    logic [9:0]         ball_x_q,      ball_x_d;
    logic [8:0]         ball_y_q,      ball_y_d;
    logic               dx_neg_q,      dx_neg_d;
    logic               dy_neg_q,      dy_neg_d;
    logic [SPD_W-1:0]   speed_q,       speed_d;
    logic [CNT_W-1:0]   serve_cnt_q,   serve_cnt_d;
    logic [3:0]         score_l_q,     score_l_d;
    logic [3:0]         score_r_q,     score_r_d;
    logic               point_pulse_q, point_pulse_d;
    logic               ball_pixel_q,  ball_pixel_d;

    logic               w_tick;
    logic signed [10:0] w_spd;
    logic signed [10:0] w_nx;
    logic signed [10:0] w_ny;
    logic signed [10:0] w_y_new;
    logic               w_dy_neg_new;
    logic signed [10:0] w_pl_top;
    logic signed [10:0] w_pr_top;
    logic               w_miss;
    logic               w_ov_l;
    logic               w_ov_r;
    logic               w_hit_l;
    logic               w_hit_r;
    logic [SPD_W-1:0]   w_speed_hit;

    pong_frame_tick u_frame_tick (
        .clk          (clk),
        .rst_n        (rst_n),
        .counter_x_i  (bus.CounterX),
        .counter_y_i  (bus.CounterY),
        .frame_tick_o (w_tick)
    );

    // ------------------------------------------------------------------
    // Candidate next position, signed so that underflow past 0 is visible
    // ------------------------------------------------------------------
    assign w_spd = $signed(11'(speed_q));
    assign w_nx  = dx_neg_q ? ($signed({1'b0, ball_x_q}) - w_spd)
                            : ($signed({1'b0, ball_x_q}) + w_spd);
    assign w_ny  = dy_neg_q ? ($signed({2'b0, ball_y_q}) - w_spd)
                            : ($signed({2'b0, ball_y_q}) + w_spd);

    always_comb begin
        w_y_new      = w_ny;
        w_dy_neg_new = dy_neg_q;
        if (w_ny[10]) begin
            w_y_new      = 11'sd0;
            w_dy_neg_new = 1'b0;
        end else if (w_ny > Y_MAX) begin
            w_y_new      = Y_MAX;
            w_dy_neg_new = 1'b1;
        end
    end

    assign w_miss = w_nx[10] || (w_nx > X_MAX);

    // Paddle overlap is judged at the ball's post-move (wall-resolved) height
    assign w_pl_top = $signed({2'b0, bus.paddle_l_y});
    assign w_pr_top = $signed({2'b0, bus.paddle_r_y});
    assign w_ov_l   = (w_y_new < (w_pl_top + PAD_H)) && ((w_y_new + BALL_S) > w_pl_top);
    assign w_ov_r   = (w_y_new < (w_pr_top + PAD_H)) && ((w_y_new + BALL_S) > w_pr_top);

    assign w_hit_l = dx_neg_q && (w_nx <= L_PAD_END) && ((w_nx + BALL_S) > L_PAD_X) && w_ov_l;
    assign w_hit_r = !dx_neg_q && ((w_nx + BALL_S) >= R_PAD_X) && (w_nx < R_PAD_END) && w_ov_r;

`ifdef PONG_BALL_SPEEDUP_EN
    localparam logic [SPD_W-1:0] MAX_SPD = SPD_W'(MAX_SPEED);
    assign w_speed_hit = (speed_q >= MAX_SPD) ? MAX_SPD : (speed_q + SPD_W'(1));
`else
    assign w_speed_hit = speed_q;
`endif

    // ------------------------------------------------------------------
    // Ball FSM: next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        dx_neg_d      = dx_neg_q;
        dy_neg_d      = dy_neg_q;
        speed_d       = speed_q;
        serve_cnt_d   = serve_cnt_q;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        point_pulse_d = 1'b0;

        unique case (state_q)
            ST_SERVE: begin
                if (w_tick) begin
                    if (serve_cnt_q == CNT_LAST) begin
                        serve_cnt_d = '0;
                        state_d     = ST_PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_PLAY: begin
                if (w_tick) begin
                    if (w_miss) begin
                        // Position is frozen; direction is kept so POINT can
                        // tell which side the ball escaped through.
                        state_d = ST_POINT;
                    end else begin
                        ball_y_d = w_y_new[8:0];
                        dy_neg_d = w_dy_neg_new;
                        if (w_hit_l) begin
                            ball_x_d = L_BOUNCE_X;
                            dx_neg_d = 1'b0;
                            speed_d  = w_speed_hit;
                        end else if (w_hit_r) begin
                            ball_x_d = R_BOUNCE_X;
                            dx_neg_d = 1'b1;
                            speed_d  = w_speed_hit;
                        end else begin
                            ball_x_d = w_nx[9:0];
                        end
                    end
                end
            end

            ST_POINT: begin
                // Leftward ball escaped on the left: right player scores.
                // Flipping dx aims the next serve at the scorer.
                if (dx_neg_q) begin
                    score_r_d = (score_r_q == 4'd9) ? 4'd0 : (score_r_q + 4'd1);
                end else begin
                    score_l_d = (score_l_q == 4'd9) ? 4'd0 : (score_l_q + 4'd1);
                end
                dx_neg_d      = !dx_neg_q;
                ball_x_d      = CX;
                ball_y_d      = CY;
                speed_d       = SPEED_INIT;
                point_pulse_d = 1'b1;
                state_d       = ST_SERVE;
            end

            default: begin
                state_d = ST_SERVE;
            end
        endcase
    end

    // Registered pixel test; ball position only moves on the frame tick
    assign ball_pixel_d = bus.inDisplayArea
        && ({1'b0, bus.CounterX} >= {1'b0, ball_x_q})
        && ({1'b0, bus.CounterX} <  ({1'b0, ball_x_q} + 11'(BALL_SIZE)))
        && ({1'b0, bus.CounterY} >= {1'b0, ball_y_q})
        && ({1'b0, bus.CounterY} <  ({1'b0, ball_y_q} + 10'(BALL_SIZE)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SERVE;
            ball_x_q      <= CX;
            ball_y_q      <= CY;
            dx_neg_q      <= 1'b0;
            dy_neg_q      <= 1'b0;
            speed_q       <= SPEED_INIT;
            serve_cnt_q   <= '0;
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            point_pulse_q <= 1'b0;
            ball_pixel_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            dx_neg_q      <= dx_neg_d;
            dy_neg_q      <= dy_neg_d;
            speed_q       <= speed_d;
            serve_cnt_q   <= serve_cnt_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            point_pulse_q <= point_pulse_d;
            ball_pixel_q  <= ball_pixel_d;
        end
    end

    assign bus.ball_pixel  = ball_pixel_q;
    assign bus.ball_x      = ball_x_q;
    assign bus.ball_y      = ball_y_q;
    assign bus.score_l     = score_l_q;
    assign bus.score_r     = score_r_q;
    assign bus.point_pulse = point_pulse_q;

    // Keep the unused upper bit of the state-limit constant referenced
    // through the wall clamp above; Y_TOP_LIM documents the ball_y range.
    logic w_y_in_range;
    assign w_y_in_range = (ball_y_q <= Y_TOP_LIM);

    // Ball must never leave its legal vertical range
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (w_y_in_range) else $error("ball_y out of range");
        end
    end

endmodule : pong_ball_engine
`default_nettype wire
